strip_control: RTL and testbench

Keypad-driven configuration controller for the channel strip. It debounces the decoded keypad hit (`kphit`/`buttonNum`) and runs a small edit state machine that lets the user pick a target (sine frequency, lowpass, or highpass) and enter a 0–7 setting. Committed settings drive `freqSelect`, `lowpassSelect` and `highpassSelect` into the sine generator and filter stages. Updates are applied only on an audio sample strobe, so filters never switch mid-sample.

---
 rtl/strip_control.sv | 263 ++++++++++++++++++++++++++
 tb/tb_strip_control.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/strip_control.sv
// Keypad configuration controller: debounces keypad hits and runs the edit FSM
// that selects a target, takes a 0-7 digit, and commits on a sample boundary.
module strip_control #(
    parameter int unsigned DEBOUNCE = 2048,
    parameter int unsigned TIMEOUT  = 4_800_000
) (
    input  logic       clk_48,
    input  logic       reset,
    input  logic       kphit,
    input  logic [3:0] buttonNum,
    input  logic       sample_tick,
    output logic [2:0] freqSelect,
    output logic [2:0] lowpassSelect,
    output logic [2:0] highpassSelect,
    output logic [1:0] target,
    output logic       pending,
    output logic       keyErr
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE + 1);
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    localparam logic [DB_W-1:0] DB_THR = DB_W'(DEBOUNCE);
    localparam logic [TO_W-1:0] TO_THR = TO_W'(TIMEOUT);

    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    typedef enum logic [1:0] {
        DB_ARMED,
        DB_PRESS_CNT,
        DB_HELD,
        DB_REL_CNT
    } db_state_t;

    typedef enum logic [1:0] {
        ED_IDLE,
        ED_SELECT,
        ED_ENTERED,
        ED_COMMIT
    } ed_state_t;

    db_state_t         db_state_q, db_state_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [DB_W-1:0]   db_cnt_inc_c;
    logic              key_evt_c;

    ed_state_t         ed_state_q, ed_state_d;
    logic [1:0]        target_q, target_d;
    logic [2:0]        shd_freq_q, shd_freq_d;
    logic [2:0]        shd_lp_q, shd_lp_d;
    logic [2:0]        shd_hp_q, shd_hp_d;
    logic [2:0]        freq_q, freq_d;
    logic [2:0]        lp_q, lp_d;
    logic [2:0]        hp_q, hp_d;
    logic              key_err_q, key_err_d;
    logic              pending_q, pending_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [TO_W-1:0]   to_inc_c;

    logic [3:0]        key_c;
    logic              is_digit_c;
    logic              is_abc_c;
    logic [1:0]        abc_tgt_c;
    logic              in_edit_c;
    logic              timeout_c;
    logic              cancel_c;
    logic              shd_wr_c;

    assign key_c        = buttonNum;
    assign is_digit_c   = ~key_c[3];
    assign is_abc_c     = (key_c >= KEY_A) && (key_c <= KEY_C);
    assign abc_tgt_c    = 2'(key_c - 4'd9);
    assign in_edit_c    = (ed_state_q == ED_SELECT) || (ed_state_q == ED_ENTERED);
    assign db_cnt_inc_c = db_cnt_q + DB_W'(1);
    assign to_inc_c     = to_cnt_q + TO_W'(1);

    // Debounce: counter stays at zero in ARMED/HELD so the first sample counts as one.
    always_comb begin
        db_state_d = db_state_q;
        db_cnt_d   = db_cnt_q;
        key_evt_c  = 1'b0;
        case (db_state_q)
            DB_ARMED, DB_PRESS_CNT: begin
                if (!kphit) begin
                    db_state_d = DB_ARMED;
                    db_cnt_d   = '0;
                end else if (db_cnt_inc_c == DB_THR) begin
                    key_evt_c  = 1'b1;
                    db_state_d = DB_HELD;
                    db_cnt_d   = '0;
                end else begin
                    db_state_d = DB_PRESS_CNT;
                    db_cnt_d   = db_cnt_inc_c;
                end
            end
            DB_HELD, DB_REL_CNT: begin
                if (kphit) begin
                    db_cnt_d = '0;
                end else if (db_cnt_inc_c == DB_THR) begin
                    db_state_d = DB_ARMED;
                    db_cnt_d   = '0;
                end else begin
                    db_state_d = DB_REL_CNT;
                    db_cnt_d   = db_cnt_inc_c;
                end
            end
            default: begin
                db_state_d = DB_ARMED;
                db_cnt_d   = '0;
            end
        endcase
    end

    // Edit FSM: a key event always takes priority over a simultaneous timeout.
    always_comb begin
        ed_state_d = ed_state_q;
        target_d   = target_q;
        shd_freq_d = shd_freq_q;
        shd_lp_d   = shd_lp_q;
        shd_hp_d   = shd_hp_q;
        freq_d     = freq_q;
        lp_d       = lp_q;
        hp_d       = hp_q;
        key_err_d  = 1'b0;
        to_cnt_d   = '0;
        timeout_c  = 1'b0;
        cancel_c   = 1'b0;
        shd_wr_c   = 1'b0;

        if (in_edit_c && !key_evt_c) begin
            if (to_inc_c == TO_THR) begin
                timeout_c = 1'b1;
            end else begin
                to_cnt_d = to_inc_c;
            end
        end

        case (ed_state_q)
            ED_IDLE: begin
                if (key_evt_c) begin
                    if (is_abc_c) begin
                        ed_state_d = ED_SELECT;
                        target_d   = abc_tgt_c;
                    end else if (key_c == KEY_D) begin
                        shd_freq_d = '0;
                        shd_lp_d   = '0;
                        shd_hp_d   = '0;
                        ed_state_d = ED_COMMIT;
                    end else begin
                        key_err_d = 1'b1;
                    end
                end
            end
            ED_SELECT: begin
                if (key_evt_c) begin
                    if (is_digit_c) begin
                        shd_wr_c   = 1'b1;
                        ed_state_d = ED_ENTERED;
                    end else if (is_abc_c) begin
                        target_d = abc_tgt_c;
                    end else if (key_c == KEY_STAR) begin
                        cancel_c = 1'b1;
                    end else begin
                        key_err_d = 1'b1;
                    end
                end else if (timeout_c) begin
                    cancel_c = 1'b1;
                end
            end
            ED_ENTERED: begin
                if (key_evt_c) begin
                    if (is_digit_c) begin
                        shd_wr_c = 1'b1;
                    end else if (key_c == KEY_HASH) begin
                        ed_state_d = ED_COMMIT;
                    end else if (key_c == KEY_STAR) begin
                        cancel_c = 1'b1;
                    end else begin
                        key_err_d = 1'b1;
                    end
                end else if (timeout_c) begin
                    cancel_c = 1'b1;
                end
            end
            ED_COMMIT: begin
                if (sample_tick) begin
                    freq_d     = shd_freq_q;
                    lp_d       = shd_lp_q;
                    hp_d       = shd_hp_q;
                    ed_state_d = ED_IDLE;
                    target_d   = 2'd0;
                end
            end
            default: begin
                ed_state_d = ED_IDLE;
            end
        endcase

        if (shd_wr_c) begin
            case (target_q)
                2'd1:    shd_freq_d = key_c[2:0];
                2'd2:    shd_lp_d   = key_c[2:0];
                2'd3:    shd_hp_d   = key_c[2:0];
                default: ;
            endcase
        end

        // Abandoning an edit restores the shadow copies from the committed values.
        if (cancel_c) begin
            ed_state_d = ED_IDLE;
            target_d   = 2'd0;
            shd_freq_d = freq_q;
            shd_lp_d   = lp_q;
            shd_hp_d   = hp_q;
        end

        pending_d = (ed_state_d == ED_ENTERED) || (ed_state_d == ED_COMMIT);
    end

    always_ff @(posedge clk_48) begin
        if (reset) begin
            db_state_q <= DB_ARMED;
            db_cnt_q   <= '0;
            ed_state_q <= ED_IDLE;
            target_q   <= 2'd0;
            shd_freq_q <= '0;
            shd_lp_q   <= '0;
            shd_hp_q   <= '0;
            freq_q     <= '0;
            lp_q       <= '0;
            hp_q       <= '0;
            key_err_q  <= 1'b0;
            pending_q  <= 1'b0;
            to_cnt_q   <= '0;
        end else begin
            db_state_q <= db_state_d;
            db_cnt_q   <= db_cnt_d;
            ed_state_q <= ed_state_d;
            target_q   <= target_d;
            shd_freq_q <= shd_freq_d;
            shd_lp_q   <= shd_lp_d;
            shd_hp_q   <= shd_hp_d;
            freq_q     <= freq_d;
            lp_q       <= lp_d;
            hp_q       <= hp_d;
            key_err_q  <= key_err_d;
            pending_q  <= pending_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign freqSelect     = freq_q;
    assign lowpassSelect  = lp_q;
    assign highpassSelect = hp_q;
    assign target         = target_q;
    assign pending        = pending_q;
    assign keyErr         = key_err_q;

endmodule

// File: tb/tb_strip_control.sv
// Bench for strip_control: directed scenarios plus randomized keypad activity
// checked cycle by cycle against a run-length / key-rule reference model.
module tb_strip_control;

    localparam int DB = 4;
    localparam int TO = 50;

    localparam int M_IDLE   = 0;
    localparam int M_SEL    = 1;
    localparam int M_ENT    = 2;
    localparam int M_COMMIT = 3;

    logic       clk_48 = 1'b0;
    logic       reset = 1'b1;
    logic       kphit = 1'b0;
    logic [3:0] buttonNum = 4'd0;
    logic       sample_tick = 1'b0;
    logic [2:0] freqSelect;
    logic [2:0] lowpassSelect;
    logic [2:0] highpassSelect;
    logic [1:0] target;
    logic       pending;
    logic       keyErr;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // reference model state
    int         m_hi = 0;
    int         m_lo = 0;
    bit         m_armed = 1'b1;
    int         m_mode = M_IDLE;
    int         m_tgt = 0;
    int         m_idle = 0;
    bit         m_err = 1'b0;
    logic [2:0] m_out [1:3];
    logic [2:0] m_shd [1:3];

    strip_control #(.DEBOUNCE(DB), .TIMEOUT(TO)) dut (
        .clk_48        (clk_48),
        .reset         (reset),
        .kphit         (kphit),
        .buttonNum     (buttonNum),
        .sample_tick   (sample_tick),
        .freqSelect    (freqSelect),
        .lowpassSelect (lowpassSelect),
        .highpassSelect(highpassSelect),
        .target        (target),
        .pending       (pending),
        .keyErr        (keyErr)
    );

    always #5 clk_48 = ~clk_48;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic model_cancel();
        m_mode = M_IDLE;
        m_tgt  = 0;
        for (int i = 1; i <= 3; i++) m_shd[i] = m_out[i];
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        bit evt;
        bit tmo;
        int om;
        evt = 1'b0;
        tmo = 1'b0;
        om  = m_mode;
        if (reset) begin
            m_hi = 0; m_lo = 0; m_armed = 1'b1; m_mode = M_IDLE;
            m_tgt = 0; m_idle = 0; m_err = 1'b0;
            for (int i = 1; i <= 3; i++) begin m_out[i] = 3'd0; m_shd[i] = 3'd0; end
            return;
        end
        if (kphit) begin m_hi++; m_lo = 0; end
        else begin m_lo++; m_hi = 0; end
        if (m_armed && kphit && m_hi == DB) begin evt = 1'b1; m_armed = 1'b0; end
        else if (!m_armed && !kphit && m_lo == DB) m_armed = 1'b1;

        m_err = 1'b0;
        if (om == M_SEL || om == M_ENT) begin
            if (evt) m_idle = 0;
            else begin
                m_idle++;
                if (m_idle == TO) begin tmo = 1'b1; m_idle = 0; end
            end
        end else m_idle = 0;

        if (evt) begin
            if (om == M_IDLE) begin
                if (buttonNum >= 10 && buttonNum <= 12) begin m_mode = M_SEL; m_tgt = int'(buttonNum) - 9; end
                else if (buttonNum == 13) begin
                    for (int i = 1; i <= 3; i++) m_shd[i] = 3'd0;
                    m_mode = M_COMMIT;
                end else m_err = 1'b1;
            end else if (om == M_SEL) begin
                if (buttonNum <= 7) begin m_shd[m_tgt] = buttonNum[2:0]; m_mode = M_ENT; end
                else if (buttonNum >= 10 && buttonNum <= 12) m_tgt = int'(buttonNum) - 9;
                else if (buttonNum == 14) model_cancel();
                else m_err = 1'b1;
            end else if (om == M_ENT) begin
                if (buttonNum <= 7) m_shd[m_tgt] = buttonNum[2:0];
                else if (buttonNum == 15) m_mode = M_COMMIT;
                else if (buttonNum == 14) model_cancel();
                else m_err = 1'b1;
            end
        end else if (tmo) model_cancel();

        if (om == M_COMMIT && sample_tick) begin
            for (int i = 1; i <= 3; i++) m_out[i] = m_shd[i];
            m_mode = M_IDLE;
            m_tgt  = 0;
        end
    endtask

    task automatic step();
        sample_tick = (cyc % 10 == 0);
        model_edge();
        @(posedge clk_48);
        #1;
        cyc++;
    endtask

    task automatic press(input logic [3:0] k);
        buttonNum = k;
        kphit = 1'b1;
        repeat (DB) step();
    endtask

    task automatic release_key();
        kphit = 1'b0;
        repeat (DB + 2) step();
    endtask

    task automatic tap(input logic [3:0] k);
        press(k);
        release_key();
    endtask

    task automatic do_edit(input logic [3:0] k, input logic [3:0] v);
        tap(k);
        tap(v);
        tap(4'd15);
        repeat (12) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        kphit = 1'b0;
        repeat (3) step();
        checks++;
        if ({freqSelect, lowpassSelect, highpassSelect, target, pending, keyErr} !== 13'd0) begin
            errors++;
            $display("FAIL reset_state: got f=%0d lp=%0d hp=%0d tgt=%0d pend=%0b err=%0b want all 0",
                     freqSelect, lowpassSelect, highpassSelect, target, pending, keyErr);
        end
        reset = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_basic_commit();
        press(4'd11);
        checks++;
        if ({target, pending} !== {2'd2, 1'b0}) begin
            errors++;
            $display("FAIL basic_select: got tgt=%0d pend=%0b want tgt=2 pend=0", target, pending);
        end
        release_key();
        press(4'd5);
        checks++;
        if ({lowpassSelect, pending} !== {3'd0, 1'b1}) begin
            errors++;
            $display("FAIL basic_digit: got lp=%0d pend=%0b want lp=0 pend=1", lowpassSelect, pending);
        end
        release_key();
        // make the # event edge coincide with a sample_tick, which must be ignored
        while ((cyc + DB - 1) % 10 != 0) step();
        press(4'd15);
        checks++;
        if ({lowpassSelect, pending} !== {3'd0, 1'b1}) begin
            errors++;
            $display("FAIL basic_coincident_tick: got lp=%0d pend=%0b want lp=0 pend=1", lowpassSelect, pending);
        end
        for (int i = 1; i <= 10; i++) begin
            step();
            checks++;
            if (i < 10) begin
                if ({lowpassSelect, pending} !== {3'd0, 1'b1}) begin
                    errors++;
                    $display("FAIL basic_wait_%0d: got lp=%0d pend=%0b want lp=0 pend=1", i, lowpassSelect, pending);
                end
            end else if ({freqSelect, lowpassSelect, highpassSelect, target, pending} !== {3'd0, 3'd5, 3'd0, 2'd0, 1'b0}) begin
                errors++;
                $display("FAIL basic_commit: got f=%0d lp=%0d hp=%0d tgt=%0d pend=%0b want 0/5/0 tgt=0 pend=0",
                         freqSelect, lowpassSelect, highpassSelect, target, pending);
            end
        end
        release_key();
    endtask

    task automatic test_bounce();
        int errs_seen;
        errs_seen = 0;
        tap(4'd10);
        checks++;
        if (target !== 2'd1) begin
            errors++;
            $display("FAIL bounce_select: got tgt=%0d want 1", target);
        end
        buttonNum = 4'd9;
        repeat (3) begin
            kphit = 1'b1;
            repeat (3) begin step(); errs_seen += int'(keyErr); end
            kphit = 1'b0;
            step(); errs_seen += int'(keyErr);
        end
        checks++;
        if (errs_seen != 0) begin
            errors++;
            $display("FAIL bounce_glitches: got %0d key errors want 0", errs_seen);
        end
        kphit = 1'b1;
        repeat (4) begin step(); errs_seen += int'(keyErr); end
        checks++;
        if (errs_seen != 1) begin
            errors++;
            $display("FAIL bounce_stable: got %0d key errors want 1", errs_seen);
        end
        repeat (100) begin step(); errs_seen += int'(keyErr); end
        checks++;
        if (errs_seen != 1) begin
            errors++;
            $display("FAIL bounce_hold: got %0d key errors want 1", errs_seen);
        end
        checks++;
        if ({target, pending} !== 3'd0) begin
            errors++;
            $display("FAIL bounce_hold_timeout: got tgt=%0d pend=%0b want 0/0", target, pending);
        end
        release_key();
    endtask

    task automatic test_invalid_digit();
        tap(4'd10);
        press(4'd9);
        checks++;
        if ({keyErr, target, pending} !== {1'b1, 2'd1, 1'b0}) begin
            errors++;
            $display("FAIL invalid_nine: got err=%0b tgt=%0d pend=%0b want err=1 tgt=1 pend=0", keyErr, target, pending);
        end
        kphit = 1'b0;
        step();
        checks++;
        if (keyErr !== 1'b0) begin
            errors++;
            $display("FAIL invalid_pulse_width: got err=%0b want 0", keyErr);
        end
        release_key();
        tap(4'd3);
        tap(4'd15);
        repeat (12) step();
        checks++;
        if ({freqSelect, lowpassSelect, highpassSelect, pending} !== {3'd3, 3'd5, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL invalid_commit: got f=%0d lp=%0d hp=%0d pend=%0b want 3/5/0 pend=0",
                     freqSelect, lowpassSelect, highpassSelect, pending);
        end
    endtask

    task automatic test_cancel_timeout();
        tap(4'd12);
        tap(4'd6);
        press(4'd14);
        checks++;
        if ({highpassSelect, target, pending} !== {3'd0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL cancel_star: got hp=%0d tgt=%0d pend=%0b want 0/0/0", highpassSelect, target, pending);
        end
        release_key();
        repeat (20) step();
        checks++;
        if (highpassSelect !== 3'd0) begin
            errors++;
            $display("FAIL cancel_no_commit: got hp=%0d want 0", highpassSelect);
        end
        tap(4'd12);
        press(4'd6);
        release_key();
        repeat (TO - 1 - (DB + 2)) step();
        checks++;
        if ({target, pending} !== {2'd3, 1'b1}) begin
            errors++;
            $display("FAIL timeout_early: got tgt=%0d pend=%0b want tgt=3 pend=1", target, pending);
        end
        step();
        checks++;
        if ({target, pending} !== {2'd0, 1'b0}) begin
            errors++;
            $display("FAIL timeout_expire: got tgt=%0d pend=%0b want tgt=0 pend=0", target, pending);
        end
        repeat (15) step();
        checks++;
        if ({freqSelect, lowpassSelect, highpassSelect} !== {3'd3, 3'd5, 3'd0}) begin
            errors++;
            $display("FAIL timeout_outputs: got f=%0d lp=%0d hp=%0d want 3/5/0", freqSelect, lowpassSelect, highpassSelect);
        end
    endtask

    task automatic test_defaults_reset();
        bit done;
        bit was_tick;
        do_edit(4'd10, 4'd5);
        do_edit(4'd11, 4'd3);
        do_edit(4'd12, 4'd2);
        checks++;
        if ({freqSelect, lowpassSelect, highpassSelect} !== {3'd5, 3'd3, 3'd2}) begin
            errors++;
            $display("FAIL defaults_setup: got f=%0d lp=%0d hp=%0d want 5/3/2", freqSelect, lowpassSelect, highpassSelect);
        end
        press(4'd13);
        checks++;
        if ({freqSelect, lowpassSelect, highpassSelect, pending} !== {3'd5, 3'd3, 3'd2, 1'b1}) begin
            errors++;
            $display("FAIL defaults_pending: got f=%0d lp=%0d hp=%0d pend=%0b want 5/3/2 pend=1",
                     freqSelect, lowpassSelect, highpassSelect, pending);
        end
        done = 1'b0;
        for (int i = 0; i < 12 && !done; i++) begin
            was_tick = (cyc % 10 == 0);
            step();
            checks++;
            if (was_tick) begin
                done = 1'b1;
                if ({freqSelect, lowpassSelect, highpassSelect, pending} !== 10'd0) begin
                    errors++;
                    $display("FAIL defaults_commit: got f=%0d lp=%0d hp=%0d pend=%0b want 0/0/0 pend=0",
                             freqSelect, lowpassSelect, highpassSelect, pending);
                end
            end else if ({freqSelect, lowpassSelect, highpassSelect} !== {3'd5, 3'd3, 3'd2}) begin
                errors++;
                $display("FAIL defaults_hold: got f=%0d lp=%0d hp=%0d want 5/3/2", freqSelect, lowpassSelect, highpassSelect);
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL defaults_tick_seen: got no sample_tick within 12 cycles want one");
        end
        release_key();

        do_edit(4'd10, 4'd4);
        tap(4'd11);
        tap(4'd6);
        press(4'd15);
        checks++;
        if ({freqSelect, pending} !== {3'd4, 1'b1}) begin
            errors++;
            $display("FAIL reset_commit_setup: got f=%0d pend=%0b want f=4 pend=1", freqSelect, pending);
        end
        reset = 1'b1;
        kphit = 1'b0;
        step();
        reset = 1'b0;
        checks++;
        if ({freqSelect, lowpassSelect, highpassSelect, target, pending, keyErr} !== 13'd0) begin
            errors++;
            $display("FAIL reset_in_commit: got f=%0d lp=%0d hp=%0d tgt=%0d pend=%0b want all 0",
                     freqSelect, lowpassSelect, highpassSelect, target, pending);
        end
        repeat (30) step();
        checks++;
        if ({freqSelect, lowpassSelect, highpassSelect, pending} !== 10'd0) begin
            errors++;
            $display("FAIL reset_no_late_commit: got f=%0d lp=%0d hp=%0d pend=%0b want all 0",
                     freqSelect, lowpassSelect, highpassSelect, pending);
        end
    endtask

    task automatic test_random();
        int n;
        int len;
        logic [12:0] exp_v;
        logic [12:0] got_v;
        n = 0;
        while (n < 3000) begin
            kphit = 1'($urandom_range(0, 1));
            buttonNum = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(8, 15));
            len = $urandom_range(1, 10);
            reset = ($urandom_range(0, 149) == 0);
            for (int i = 0; i < len; i++) begin
                step();
                n++;
                reset = 1'b0;
                exp_v = {m_out[1], m_out[2], m_out[3], 2'(m_tgt),
                         (m_mode == M_ENT || m_mode == M_COMMIT), m_err};
                got_v = {freqSelect, lowpassSelect, highpassSelect, target, pending, keyErr};
                checks++;
                if (got_v !== exp_v) begin
                    errors++;
                    $display("FAIL random_cycle_%0d: got f/lp/hp/tgt/pend/err=%0d/%0d/%0d/%0d/%0b/%0b want %0d/%0d/%0d/%0d/%0b/%0b",
                             cyc, got_v[12:10], got_v[9:7], got_v[6:4], got_v[3:2], got_v[1], got_v[0],
                             exp_v[12:10], exp_v[9:7], exp_v[6:4], exp_v[3:2], exp_v[1], exp_v[0]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 1; i <= 3; i++) begin m_out[i] = 3'd0; m_shd[i] = 3'd0; end
        test_reset();
        test_basic_commit();
        test_bounce();
        test_invalid_digit();
        test_cancel_timeout();
        test_defaults_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
